alu_cmd_sequencer: RTL and testbench

- Upstream command stage for the ALU (fixed-point, floating-point and converter units).
- Accepts 192-bit command words from the host interface and buffers them in a FIFO.
- Issues one command at a time: drives operands and one-cycle start pulses, waits for every enabled unit's done, then presents one packed 132-bit result with a valid/ready handshake for the host write-back path.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_cmd_sequencer_if.sv | 23 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/alu_cmd_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: command/result layouts and FSM states.
// Field order of both structs matches the host bus bit layout, MSB first.
package alu_seq_pkg;

  localparam int CMD_W = 192;
  localparam int RES_W = 132;

  typedef struct packed {
    logic [31:0] conv_in;
    logic [31:0] float_b;
    logic [31:0] float_a;
    logic [31:0] fix_b;
    logic [31:0] fix_a;
    logic [21:0] reserved;
    logic [2:0]  float_mode;
    logic [2:0]  fix_mode;
    logic        conv_en;
    logic        float_en;
    logic        fix_en;
    logic        conv_mode;
  } cmd_t;

  typedef struct packed {
    logic        timeout;
    logic        conv_done;
    logic        float_done;
    logic        fix_done;
    logic [31:0] conv_res;
    logic [31:0] float_res;
    logic [63:0] fix_res;
  } res_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Host-side bus of the sequencer: command push channel, result valid/ready channel, busy.
// master = host driving commands and accepting results; slave = the sequencer.
interface alu_cmd_sequencer_if;

  logic                cmd_valid;
  logic                cmd_ready;
  alu_seq_pkg::cmd_t   cmd_data;
  logic                res_valid;
  logic                res_ready;
  alu_seq_pkg::res_t   res_data;
  logic                busy;

  modport master (
    output cmd_valid, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, busy
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; read data is the head entry, visible the cycle after its push.
// Backpressure: ready_o is registered (not full next cycle); push and pop may coincide.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             ready_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ready_q;
  assign do_pop  = pop_i & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign ready_o = ready_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers host commands, issues them one at a time to the ALU units and returns one packed result;
// push to res_valid is 4 cycles with single-cycle units, result held until res_ready. Watchdog: ALU_TIMEOUT_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  host,
  output logic [2:0]          fix_mode,
  output logic [2:0]          float_mode,
  output logic                converter_mode,
  output logic [31:0]         fix_a,
  output logic [31:0]         fix_b,
  output logic [31:0]         float_a,
  output logic [31:0]         float_b,
  output logic [31:0]         converter_in,
  output logic                fix_start,
  output logic                float_start,
  output logic                converter_start,
  input  logic                fix_done,
  input  logic                float_done,
  input  logic                converter_done,
  input  logic [63:0]         fix_result,
  input  logic [31:0]         float_result,
  input  logic [31:0]         converter_out
);

  state_t     state_q;
  cmd_t       cmd_q;
  res_t       res_q;
  logic       res_valid_q;
  logic       fix_start_q, float_start_q, conv_start_q;
  cmd_t       fifo_rdata;
  logic       fifo_empty, fifo_pop;
  logic [2:0] en, done_in, flags_d;
  logic       wd_expire;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (host.cmd_valid),
    .wdata_i (host.cmd_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .ready_o (host.cmd_ready)
  );

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign en       = {cmd_q.conv_en, cmd_q.float_en, cmd_q.fix_en};
  assign done_in  = {converter_done, float_done, fix_done} & en;
  assign flags_d  = {res_q.conv_done, res_q.float_done, res_q.fix_done} | done_in;

`ifdef ALU_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q <= '0;
    end else if (state_q == ISSUE) begin
      wd_q <= '0;
    end else if (state_q == WAIT) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  // Fires in the last of TIMEOUT_CYCLES wait cycles, so OUTPUT follows immediately after it.
  assign wd_expire = (state_q == WAIT) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      res_q         <= '0;
      res_valid_q   <= 1'b0;
      fix_start_q   <= 1'b0;
      float_start_q <= 1'b0;
      conv_start_q  <= 1'b0;
    end else begin
      fix_start_q   <= 1'b0;
      float_start_q <= 1'b0;
      conv_start_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cmd_q         <= fifo_rdata;
            fix_start_q   <= fifo_rdata.fix_en;
            float_start_q <= fifo_rdata.float_en;
            conv_start_q  <= fifo_rdata.conv_en;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          res_q <= '0;
          if (en == 3'b000) begin
            res_valid_q <= 1'b1;
            state_q     <= OUTPUT;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (done_in[0]) res_q.fix_res   <= fix_result;
          if (done_in[1]) res_q.float_res <= float_result;
          if (done_in[2]) res_q.conv_res  <= converter_out;
          res_q.fix_done   <= flags_d[0];
          res_q.float_done <= flags_d[1];
          res_q.conv_done  <= flags_d[2];
          if (flags_d == en) begin
            res_valid_q <= 1'b1;
            state_q     <= OUTPUT;
          end else if (wd_expire) begin
            res_q.timeout <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (host.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_reserved;
  assign unused_reserved = ^cmd_q.reserved;

  assign fix_mode        = cmd_q.fix_mode;
  assign float_mode      = cmd_q.float_mode;
  assign converter_mode  = cmd_q.conv_mode;
  assign fix_a           = cmd_q.fix_a;
  assign fix_b           = cmd_q.fix_b;
  assign float_a         = cmd_q.float_a;
  assign float_b         = cmd_q.float_b;
  assign converter_in    = cmd_q.conv_in;
  assign fix_start       = fix_start_q;
  assign float_start     = float_start_q;
  assign converter_start = conv_start_q;
  assign host.res_valid  = res_valid_q;
  assign host.res_data   = res_q;
  assign host.busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench: behavioural unit responders plus a result scoreboard
// whose expectations come from the command fields alone.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if hif();

  logic [2:0]  fix_mode, float_mode;
  logic        converter_mode;
  logic [31:0] fix_a, fix_b, float_a, float_b, converter_in;
  logic        fix_start, float_start, converter_start;
  logic        fix_done, float_done, converter_done;
  logic [63:0] fix_result;
  logic [31:0] float_result, converter_out;

  alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .host(hif),
    .fix_mode(fix_mode), .float_mode(float_mode), .converter_mode(converter_mode),
    .fix_a(fix_a), .fix_b(fix_b), .float_a(float_a), .float_b(float_b),
    .converter_in(converter_in),
    .fix_start(fix_start), .float_start(float_start), .converter_start(converter_start),
    .fix_done(fix_done), .float_done(float_done), .converter_done(converter_done),
    .fix_result(fix_result), .float_result(float_result), .converter_out(converter_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nfix = 0, nfloat = 0, nconv = 0;
  int fix_lat = 1, float_lat = 1, conv_lat = 1;  // 0 = unit never answers
  bit fix_spur = 1'b0;                          // fix unit also answers float starts
  logic [RES_W-1:0] expq[$];

  // Reference: what the returned word must be given only the command.
  function automatic logic [RES_W-1:0] model(input cmd_t c);
    logic [63:0] fx;
    logic [31:0] fl, cv;
    fx = c.fix_en   ? {32'b0, c.fix_a} * {32'b0, c.fix_b} : 64'b0;
    fl = c.float_en ? (c.float_a ^ c.float_b) : 32'b0;
    cv = c.conv_en  ? (c.conv_mode ? ~c.conv_in : c.conv_in + 32'd1) : 32'b0;
    return {1'b0, c.conv_en, c.float_en, c.fix_en, cv, fl, fx};
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return c;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Unit responders: done is raised lat cycles after the start pulse; results are garbage otherwise.
  initial begin
    fix_done = 1'b0; fix_result = '0;
    forever begin
      @(posedge clk); #1;
      fix_result = {$urandom, $urandom};
      if ((fix_start || (fix_spur && float_start)) && fix_lat > 0) begin
        repeat (fix_lat) @(posedge clk);
        #1 fix_done = 1'b1; fix_result = {32'b0, fix_a} * {32'b0, fix_b};
        @(posedge clk); #1 fix_done = 1'b0;
      end
    end
  end

  initial begin
    float_done = 1'b0; float_result = '0;
    forever begin
      @(posedge clk); #1;
      float_result = $urandom;
      if (float_start && float_lat > 0) begin
        repeat (float_lat) @(posedge clk);
        #1 float_done = 1'b1; float_result = float_a ^ float_b;
        @(posedge clk); #1 float_done = 1'b0;
      end
    end
  end

  initial begin
    converter_done = 1'b0; converter_out = '0;
    forever begin
      @(posedge clk); #1;
      converter_out = $urandom;
      if (converter_start && conv_lat > 0) begin
        repeat (conv_lat) @(posedge clk);
        #1 converter_done = 1'b1;
        converter_out = converter_mode ? ~converter_in : converter_in + 32'd1;
        @(posedge clk); #1 converter_done = 1'b0;
      end
    end
  end

  // Scoreboard and hold-stability monitor.
  initial begin
    bit prev_hold;
    logic [RES_W-1:0] prev_data, e;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hold = 1'b0;
      end else begin
        nfix += int'(fix_start); nfloat += int'(float_start); nconv += int'(converter_start);
        if (prev_hold) begin
          checks++;
          if (hif.res_valid !== 1'b1 || hif.res_data !== prev_data) begin
            errors++;
            $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h",
                     hif.res_valid, hif.res_data, prev_data);
          end
        end
        if (hif.res_valid === 1'b1 && hif.res_ready === 1'b1) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got %h with nothing outstanding", hif.res_data);
          end else begin
            e = expq.pop_front();
            if (hif.res_data !== e) begin
              errors++;
              $display("FAIL result_order: got %h required %h", hif.res_data, e);
            end
          end
        end
        prev_hold = hif.res_valid && !hif.res_ready;
        prev_data = hif.res_data;
      end
    end
  end

  task automatic push_cmd(input cmd_t c, output int tp);
    bit acc;
    tp = -1;
    hif.cmd_valid = 1'b1;
    hif.cmd_data  = c;
    for (int i = 0; i < 400; i++) begin
      acc = hif.cmd_ready;
      @(posedge clk); #1;
      if (acc) begin
        tp = cyc - 1;
        break;
      end
    end
    hif.cmd_valid = 1'b0;
    if (tp < 0) begin
      checks++; errors++;
      $display("FAIL push_timeout: cmd_ready never high, required acceptance");
    end else begin
      expq.push_back(model(c));
    end
  endtask

  // Returns the cycle res_valid is first seen and the cycle fix_done was seen (-1 if never).
  task automatic wait_res(input int limit, output int tv, output int td);
    tv = -1; td = -1;
    for (int i = 0; i < limit; i++) begin
      if (fix_done && td < 0) td = cyc;
      if (hif.res_valid) begin
        tv = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    hif.cmd_valid = 1'b0; hif.cmd_data = '0; hif.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    checks++; if (hif.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: %b required 0", hif.res_valid); end
    checks++; if (hif.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: %b required 1", hif.cmd_ready); end
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", hif.busy); end
    checks++; if (hif.res_data !== '0) begin errors++; $display("FAIL reset_res_data: %h required 0", hif.res_data); end
    checks++;
    if ({fix_start, float_start, converter_start, fix_a, converter_in, fix_mode, converter_mode} !== '0) begin
      errors++; $display("FAIL reset_unit_outputs: starts=%b%b%b fix_a=%h required all 0",
                         fix_start, float_start, converter_start, fix_a);
    end
  endtask

  task automatic test_single_fix();
    cmd_t c; int tp, tv, td, n0;
    c = '0; c.fix_en = 1'b1; c.fix_a = 32'd5; c.fix_b = 32'd7;
    fix_lat = 3;
    n0 = nfix;
    push_cmd(c, tp);
    wait_res(40, tv, td);
    checks++; if (tv < 0) begin errors++; $display("FAIL single_fix_no_result: required res_valid"); end
    checks++; if (td < 0 || tv != td + 1) begin errors++; $display("FAIL single_fix_latency: valid@%0d done@%0d required done+1", tv, td); end
    checks++; if (tv != tp + 6) begin errors++; $display("FAIL single_fix_push_to_valid: %0d cycles required 6", tv - tp); end
    checks++; if (hif.res_data[63:0] !== 64'd35) begin errors++; $display("FAIL single_fix_value: %0d required 35", hif.res_data[63:0]); end
    checks++; if (hif.res_data[131:128] !== 4'b0001) begin errors++; $display("FAIL single_fix_status: %b required 0001", hif.res_data[131:128]); end
    @(posedge clk); #1;
    checks++; if (nfix - n0 != 1) begin errors++; $display("FAIL single_fix_starts: %0d pulses required 1", nfix - n0); end
    checks++; if (hif.res_valid !== 1'b0) begin errors++; $display("FAIL single_fix_release: valid=%b required 0", hif.res_valid); end
  endtask

  task automatic test_best_case();
    cmd_t c; int tp, tv, td;
    c = rand_cmd(); c.fix_en = 1'b1; c.float_en = 1'b1; c.conv_en = 1'b1;
    fix_lat = 1; float_lat = 1; conv_lat = 1;
    push_cmd(c, tp);
    wait_res(40, tv, td);
    checks++; if (tv != tp + 4) begin errors++; $display("FAIL best_case_latency: %0d cycles required 4", tv - tp); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_units();
    cmd_t c; int tp, tv, td;
    c = rand_cmd(); c.fix_en = 1'b1; c.float_en = 1'b1; c.conv_en = 1'b1;
    fix_lat = 3; float_lat = 1; conv_lat = 1;
    push_cmd(c, tp);
    wait_res(40, tv, td);
    checks++; if (td < 0 || tv != td + 1) begin errors++; $display("FAIL all_units_wait_last: valid@%0d fix_done@%0d required fix_done+1", tv, td); end
    checks++; if (hif.res_data[130:128] !== 3'b111) begin errors++; $display("FAIL all_units_status: %b required 111", hif.res_data[130:128]); end
    @(posedge clk); #1;
  endtask

  task automatic test_no_enable();
    cmd_t c; int tp, tv, td, n0;
    c = rand_cmd(); c.fix_en = 1'b0; c.float_en = 1'b0; c.conv_en = 1'b0;
    n0 = nfix + nfloat + nconv;
    push_cmd(c, tp);
    wait_res(40, tv, td);
    checks++; if (tv != tp + 3) begin errors++; $display("FAIL no_enable_latency: %0d cycles required 3", tv - tp); end
    checks++; if (hif.res_data !== '0) begin errors++; $display("FAIL no_enable_data: %h required 0", hif.res_data); end
    @(posedge clk); #1;
    checks++; if (nfix + nfloat + nconv != n0) begin errors++; $display("FAIL no_enable_starts: %0d pulses required 0", nfix + nfloat + nconv - n0); end
  endtask

  task automatic test_spurious_done();
    cmd_t c; int tp, tv, td;
    c = rand_cmd(); c.fix_en = 1'b0; c.float_en = 1'b1; c.conv_en = 1'b0;
    fix_spur = 1'b1; fix_lat = 1; float_lat = 3;
    push_cmd(c, tp);
    wait_res(40, tv, td);
    checks++; if (td < 0) begin errors++; $display("FAIL spurious_setup: fix_done not seen, required it"); end
    checks++; if (hif.res_data[128] !== 1'b0 || hif.res_data[63:0] !== 64'd0) begin
      errors++; $display("FAIL spurious_fix_ignored: bit128=%b fix=%h required 0 and 0", hif.res_data[128], hif.res_data[63:0]);
    end
    checks++; if (hif.res_data[129] !== 1'b1) begin errors++; $display("FAIL spurious_float_done: %b required 1", hif.res_data[129]); end
    @(posedge clk); #1;
    fix_spur = 1'b0;
  endtask

  task automatic test_fifo_full();
    cmd_t c, held; int tp, tp0, tv, td, rdy_seen;
    fix_lat = $urandom_range(1, 3); float_lat = $urandom_range(1, 3); conv_lat = $urandom_range(1, 3);
    hif.res_ready = 1'b0;
    push_cmd(rand_cmd(), tp);          // occupies the FSM, stuck on its result
    wait_res(40, tv, td);
    checks++; if (tv < 0) begin errors++; $display("FAIL fifo_full_first: no result, required one"); end
    tp0 = -1;
    for (int k = 0; k < DEPTH; k++) begin
      c = rand_cmd();
      push_cmd(c, tp);
      if (k == 0) tp0 = tp;
    end
    checks++; if (tp != tp0 + DEPTH - 1) begin errors++; $display("FAIL fifo_full_backtoback: span %0d required %0d", tp - tp0, DEPTH - 1); end
    checks++; if (hif.cmd_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready: %b required 0", hif.cmd_ready); end
    held = rand_cmd();
    hif.cmd_valid = 1'b1; hif.cmd_data = held;
    rdy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      rdy_seen += int'(hif.cmd_ready);
    end
    checks++; if (rdy_seen != 0) begin errors++; $display("FAIL fifo_full_hold: ready high %0d cycles required 0", rdy_seen); end
    hif.res_ready = 1'b1;
    push_cmd(held, tp);
    for (int i = 0; i < 400 && expq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL fifo_full_drain: %0d outstanding required 0", expq.size()); end
  endtask

  task automatic test_random();
    bit pushed_all; int tp;
    pushed_all = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          fix_lat = $urandom_range(1, 4); float_lat = $urandom_range(1, 4); conv_lat = $urandom_range(1, 4);
          push_cmd(rand_cmd(), tp);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        pushed_all = 1'b1;
      end
      begin
        for (int i = 0; i < 3000 && !(pushed_all && expq.size() == 0); i++) begin
          hif.res_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    hif.res_ready = 1'b1;
    checks++; if (expq.size() != 0 || !pushed_all) begin errors++; $display("FAIL random_drain: %0d outstanding required 0", expq.size()); end
  endtask

`ifdef ALU_TIMEOUT_EN
  task automatic test_timeout();
    cmd_t c; int tp, tv, td;
    c = rand_cmd(); c.fix_en = 1'b1; c.float_en = 1'b0; c.conv_en = 1'b0;
    fix_lat = 0;
    push_cmd(c, tp);
    expq[expq.size() - 1] = {1'b1, 3'b000, 128'b0};
    wait_res(60, tv, td);
    checks++; if (tv != tp + 3 + TO) begin errors++; $display("FAIL timeout_latency: %0d cycles required %0d", tv - tp, 3 + TO); end
    checks++; if (hif.res_data[131:128] !== 4'b1000) begin errors++; $display("FAIL timeout_status: %b required 1000", hif.res_data[131:128]); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_in_wait();
    cmd_t c; int tp, seen;
    c = rand_cmd(); c.fix_en = 1'b1; c.float_en = 1'b0; c.conv_en = 1'b0;
    fix_lat = 0;
    push_cmd(c, tp);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hif.busy !== 1'b1 || hif.res_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_setup: busy=%b valid=%b required 1 0", hif.busy, hif.res_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL rst_wait_busy: %b required 0", hif.busy); end
    checks++; if (hif.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: %b required 1", hif.cmd_ready); end
    rst = 1'b1;
    expq.delete();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      seen += int'(hif.res_valid);
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_wait_no_result: valid %0d cycles required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single_fix();
    test_best_case();
    test_all_units();
    test_no_enable();
    test_spurious_done();
    test_fifo_full();
    test_random();
`ifdef ALU_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    test_best_case();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1);
  end

endmodule
